// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the mux select sequencer.
package mux_seq_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned GAP_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // First select of a word: 0 when LSB-first, 7 when MSB-first.
  function automatic logic [SEL_W-1:0] sel_first(input logic msb_first);
    return msb_first ? SEL_W'(7) : SEL_W'(0);
  endfunction

  // Final select of a word; the opposite end of the sweep.
  function automatic logic [SEL_W-1:0] sel_last(input logic msb_first);
    return msb_first ? SEL_W'(0) : SEL_W'(7);
  endfunction

endpackage

// File: rtl/sel_counter.sv
// 3-bit select counter: load-to-start, step toward the end, clear to 0.
// tc is registered alongside sel and is high while sel sits on the final position.
module sel_counter
  import mux_seq_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  output logic [SEL_W-1:0] sel,
  output logic             tc
);

  localparam logic [SEL_W-1:0] START   = sel_first(MSB_FIRST);
  localparam logic [SEL_W-1:0] END_SEL = sel_last(MSB_FIRST);

  logic [SEL_W-1:0] sel_step;

  assign sel_step = MSB_FIRST ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));

  // Start and end always differ, so a fresh load never lands on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      sel <= START;
      tc  <= 1'b0;
    end else if (step) begin
      sel <= sel_step;
      tc  <= (sel_step == END_SEL);
    end else if (clear) begin
      sel <= '0;
      tc  <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial controller feeding an 8-to-1 mux: holds a word on the
// mux data inputs and sweeps the select one position per clock.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned GAP       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] mux_a,
  output logic [SEL_W-1:0]  mux_s,
  output logic              mux_en,
  output logic              last,
  output logic              busy
);

  localparam bit NO_GAP = (GAP == 0);
  localparam logic [GAP_W-1:0] GAP_INIT = NO_GAP ? GAP_W'(0) : GAP_W'(GAP - 1);

  state_t           state, state_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic             accept;
  logic             cnt_load, cnt_step, cnt_clear;
  logic             en_next;

  // Back-to-back acceptance on the final bit is only offered with no gap.
  assign din_ready = !rst && ((state == ST_IDLE) ||
                              ((state == ST_SEND) && last && NO_GAP));
  assign accept    = din_valid && din_ready;

  sel_counter #(
    .MSB_FIRST(MSB_FIRST)
  ) u_sel_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .step (cnt_step),
    .clear(cnt_clear),
    .sel  (mux_s),
    .tc   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      mux_a   <= '0;
      mux_en  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
      mux_en  <= en_next;
      busy    <= (state_next != ST_IDLE);
      if (cnt_load) mux_a <= din;
    end
  end

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    cnt_clear  = 1'b0;
    en_next    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_load   = 1'b1;
          en_next    = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!last) begin
          cnt_step = 1'b1;
          en_next  = 1'b1;
        end else if (accept) begin
          cnt_load = 1'b1;
          en_next  = 1'b1;
        end else if (!NO_GAP) begin
          cnt_clear  = 1'b1;
          gap_next   = GAP_INIT;
          state_next = ST_GAP;
        end else begin
          cnt_clear  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_next = ST_IDLE;
        else               gap_next   = gap_cnt - GAP_W'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer: LSB-first, MSB-first and gapped variants.
module tb_mux_sel_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;

  logic       l_ready, l_en, l_last, l_busy;
  logic [7:0] l_a;
  logic [2:0] l_s;
  logic       m_ready, m_en, m_last, m_busy;
  logic [7:0] m_a;
  logic [2:0] m_s;
  logic       g_ready, g_en, g_last, g_busy;
  logic [7:0] g_a;
  logic [2:0] g_s;

  int checks = 0;
  int errors = 0;

  mux_sel_sequencer #(.MSB_FIRST(1'b0), .GAP(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .mux_a(l_a), .mux_s(l_s), .mux_en(l_en), .last(l_last), .busy(l_busy)
  );

  mux_sel_sequencer #(.MSB_FIRST(1'b1), .GAP(0)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .mux_a(m_a), .mux_s(m_s), .mux_en(m_en), .last(m_last), .busy(m_busy)
  );

  mux_sel_sequencer #(.MSB_FIRST(1'b0), .GAP(2)) u_gap (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(g_ready),
    .mux_a(g_a), .mux_s(g_s), .mux_en(g_en), .last(g_last), .busy(g_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Behaviour of the downstream 8-to-1 mux.
  function automatic logic mux_y(input logic [7:0] a, input logic [2:0] s, input logic en);
    return en ? a[s] : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] word;
    rst = 1'b0;
    din = 8'h00;
    din_valid = 1'b0;
    tick();

    // Reset values
    rst = 1'b1;
    tick();
    check("rst_a",     32'(l_a), 32'h00);
    check("rst_s",     32'(l_s), 32'd0);
    check("rst_en",    32'(l_en), 32'd0);
    check("rst_last",  32'(l_last), 32'd0);
    check("rst_busy",  32'(l_busy), 32'd0);
    check("rst_ready", 32'(l_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", 32'(l_ready), 32'd1);

    // LSB-first single word 0xAA
    word = 8'hAA;
    din = word;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_en",    32'(l_en), 32'd1);
      check("lsb_s",     32'(l_s), 32'(i));
      check("lsb_y",     32'(mux_y(l_a, l_s, l_en)), 32'(i % 2));
      check("lsb_last",  32'(l_last), 32'(i == 7));
      check("lsb_busy",  32'(l_busy), 32'd1);
      check("lsb_ready", 32'(l_ready), 32'(i == 7));
      tick();
    end
    check("lsb_end_en",    32'(l_en), 32'd0);
    check("lsb_end_s",     32'(l_s), 32'd0);
    check("lsb_end_busy",  32'(l_busy), 32'd0);
    check("lsb_end_ready", 32'(l_ready), 32'd1);
    check("lsb_end_a",     32'(l_a), 32'hAA);

    // MSB-first single word 0xC3
    do_reset();
    din = 8'hC3;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    begin
      logic [7:0] ybits;
      ybits = 8'b11000011;
      for (int i = 0; i < 8; i++) begin
        check("msb_s",    32'(m_s), 32'(7 - i));
        check("msb_y",    32'(mux_y(m_a, m_s, m_en)), 32'(ybits[7 - i]));
        check("msb_last", 32'(m_last), 32'(i == 7));
        tick();
      end
    end
    check("msb_end_en", 32'(m_en), 32'd0);
    check("msb_end_s",  32'(m_s), 32'd0);

    // Back-to-back 0x0F then 0xF0 with no gap
    do_reset();
    din = 8'h0F;
    din_valid = 1'b1;
    tick();
    din = 8'hF0;
    for (int c = 0; c < 16; c++) begin
      check("b2b_en",    32'(l_en), 32'd1);
      check("b2b_s",     32'(l_s), 32'(c % 8));
      check("b2b_a",     32'(l_a), (c < 8) ? 32'h0F : 32'hF0);
      check("b2b_ready", 32'(l_ready), 32'((c % 8) == 7));
      tick();
      if (c == 7) din_valid = 1'b0;
    end
    check("b2b_end_en", 32'(l_en), 32'd0);

    // GAP=2 with two back-to-back valid words
    do_reset();
    din = 8'hA5;
    din_valid = 1'b1;
    tick();
    din = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      check("gap_w1_en",    32'(g_en), 32'd1);
      check("gap_w1_ready", 32'(g_ready), 32'd0);
      check("gap_w1_y",     32'(mux_y(g_a, g_s, g_en)), 32'(word_bit(8'hA5, i)));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check("gap_en",    32'(g_en), 32'd0);
      check("gap_s",     32'(g_s), 32'd0);
      check("gap_busy",  32'(g_busy), 32'd1);
      check("gap_ready", 32'(g_ready), 32'd0);
      check("gap_a",     32'(g_a), 32'hA5);
      tick();
    end
    check("gap_idle_en",    32'(g_en), 32'd0);
    check("gap_idle_busy",  32'(g_busy), 32'd0);
    check("gap_idle_ready", 32'(g_ready), 32'd1);
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("gap_w2_s", 32'(g_s), 32'(i));
      check("gap_w2_y", 32'(mux_y(g_a, g_s, g_en)), 32'(word_bit(8'h3C, i)));
      tick();
    end
    check("gap_w2_end_busy", 32'(g_busy), 32'd1);

    // Valid pulse mid-word is ignored
    do_reset();
    din = 8'h33;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("ign_a", 32'(l_a), 32'h33);
      din = 8'h55;
      din_valid = (i == 3);
      tick();
      din_valid = 1'b0;
    end
    check("ign_end_en", 32'(l_en), 32'd0);
    check("ign_end_a",  32'(l_a), 32'h33);

    // Reset mid-word at select 4, then a fresh word
    do_reset();
    din = 8'hFF;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_pre_s", 32'(l_s), 32'd4);
    rst = 1'b1;
    tick();
    check("abort_a",    32'(l_a), 32'h00);
    check("abort_s",    32'(l_s), 32'd0);
    check("abort_en",   32'(l_en), 32'd0);
    check("abort_last", 32'(l_last), 32'd0);
    check("abort_busy", 32'(l_busy), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_ready", 32'(l_ready), 32'd1);
    din = 8'h81;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("abort_new_a", 32'(l_a), 32'h81);
    for (int i = 0; i < 8; i++) begin
      check("abort_new_s", 32'(l_s), 32'(i));
      check("abort_new_y", 32'(mux_y(l_a, l_s, l_en)), 32'(word_bit(8'h81, i)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic word_bit(input logic [7:0] w, input int i);
    return w[i[2:0]];
  endfunction

endmodule
